ym_ts_bus_sequencer: RTL and testbench

- Synchronous TurboSound bus controller between the Z80 I/O bus and the two YM2149 chips.
- Captures CPU OUTs to #FFFD/#BFFD into a small ordered queue, then replays them to the shared YM bus as timed address-latch and data-write cycles.
- Owns the TurboSound chip-select state.
- Handles CPU reads of #FFFD; asserts wait_n when a read arrives while queued writes are still draining.

---
 rtl/ym_ts_pkg.sv | 41 ++++
 rtl/ym_ts_fifo.sv | 48 ++++
 rtl/ym_ts_bus_sequencer.sv | 150 +++++++++++++++
 tb/tb_ym_ts_bus_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym_ts_pkg.sv
// Shared types and constants for the TurboSound YM bus sequencer.
package ym_ts_pkg;

    typedef enum logic [1:0] {
        ENT_ADDR = 2'd0,
        ENT_DATA = 2'd1,
        ENT_SEL  = 2'd2
    } ent_type_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        READ
    } fsm_state_t;

    typedef struct packed {
        ent_type_t  kind;
        logic [7:0] data;
    } entry_t;

    localparam logic [15:0] PORT_REG_SEL  = 16'hFFFD;
    localparam logic [15:0] PORT_REG_DATA = 16'hBFFD;
    localparam logic [4:0]  TS_SEL_PREFIX = 5'b11111;

    // The two ports differ only in A14; #FFFD carries both register numbers
    // and TurboSound chip-select commands.
    function automatic entry_t classify(input logic a14, input logic [7:0] d);
        entry_t e;
        e.data = d;
        if (a14 == PORT_REG_DATA[14])
            e.kind = ENT_DATA;
        else if (d[7:3] == TS_SEL_PREFIX)
            e.kind = ENT_SEL;
        else
            e.kind = ENT_ADDR;
        return e;
    endfunction

endpackage

// File: rtl/ym_ts_fifo.sv
// Small synchronous first-word-fall-through FIFO holding queued YM bus entries.
module ym_ts_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ym_ts_bus_sequencer.sv
// TurboSound bus controller: queues CPU OUTs to #FFFD/#BFFD and replays them
// as timed address-latch / data-write cycles on the shared YM2149 bus.
module ym_ts_bus_sequencer
    import ym_ts_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       iorq,
    input  logic       wr,
    input  logic       m1,
    input  logic       a15,
    input  logic       a14,
    input  logic       a1,
    input  logic [7:0] d,
    output logic       ym_bdir,
    output logic       ym_bc1,
    output logic [1:0] ym_sel,
    output logic [7:0] ym_dout,
    output logic       ym_doe,
    output logic       wait_n,
    output logic       busy,
    output logic       ovf
);

    logic       io_wr;
    logic       io_rd;
    logic       io_wr_q;
    logic       push_q;
    entry_t     push_entry;
    entry_t     head;
    entry_t     cur;
    entry_t     cur_n;
    logic [$bits(entry_t)-1:0] rd_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    fsm_state_t state;
    fsm_state_t state_n;
    logic [2:0] cnt;
    logic [2:0] cnt_n;
    logic [1:0] sel;
    logic [1:0] sel_n;

    assign io_wr = !iorq && !wr && m1 && a15 && !a1;
    assign io_rd = !iorq && wr && m1 && a15 && (a14 == PORT_REG_SEL[14]) && !a1;

    // One event per OUT: rising edge of the sampled decode, entry pushed a cycle later.
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            io_wr_q    <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
            ovf        <= 1'b0;
        end else begin
            io_wr_q    <= io_wr;
            push_q     <= io_wr && !io_wr_q;
            push_entry <= classify(a14, d);
            if (push_q && fifo_full && !fifo_pop)
                ovf <= 1'b1;
        end
    end

    ym_ts_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(entry_t))
    ) u_fifo (
        .clk    (cpu_clock),
        .clr_n  (reset),
        .push   (push_q),
        .pop    (fifo_pop),
        .wr_data(push_entry),
        .rd_data(rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head = entry_t'(rd_data);

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= '0;
            sel   <= 2'b10;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cur   <= cur_n;
            sel   <= sel_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cur_n    = cur;
        sel_n    = sel;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.kind == ENT_SEL) begin
                        // d[0] is the chip number; ym_sel is active low.
                        sel_n = head.data[0] ? 2'b01 : 2'b10;
                    end else begin
                        cur_n   = head;
                        cnt_n   = 3'(SETUP_CYC - 1);
                        state_n = SETUP;
                    end
                end else if (io_rd) begin
                    state_n = READ;
                end
            end
            SETUP: begin
                if (cnt == 3'd0) begin
                    cnt_n   = 3'(PULSE_CYC - 1);
                    state_n = PULSE;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            PULSE: begin
                if (cnt == 3'd0)
                    state_n = HOLD;
                else
                    cnt_n = cnt - 3'd1;
            end
            HOLD: state_n = IDLE;
            READ: begin
                if (!io_rd)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ym_bdir = (state == PULSE);
    assign ym_bc1  = ((state == PULSE) && (cur.kind == ENT_ADDR)) || (state == READ);
    assign ym_doe  = (state == SETUP) || (state == PULSE) || (state == HOLD);
    assign ym_dout = cur.data;
    assign ym_sel  = sel;
    assign wait_n  = !(io_rd && (!fifo_empty || ((state != IDLE) && (state != READ))));
    assign busy    = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ym_ts_bus_sequencer.sv
// Self-checking bench: a schedule-based model predicts every bus cycle from
// the push times of accepted OUTs and compares the DUT outputs each cycle.
module tb_ym_ts_bus_sequencer;

    localparam int DEPTH     = 4;
    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 2;
    localparam logic [1:0] K_ADDR = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_SEL  = 2'd2;
    localparam int NEVER = 32'h7fff_ffff;

    logic       cpu_clock = 1'b0;
    logic       reset, iorq, wr, m1, a15, a14, a1;
    logic [7:0] d;
    logic       ym_bdir, ym_bc1, ym_doe, wait_n, busy, ovf;
    logic [1:0] ym_sel;
    logic [7:0] ym_dout;

    ym_ts_bus_sequencer #(
        .DEPTH(DEPTH),
        .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC)
    ) dut (
        .cpu_clock(cpu_clock),
        .reset    (reset),
        .iorq     (iorq),
        .wr       (wr),
        .m1       (m1),
        .a15      (a15),
        .a14      (a14),
        .a1       (a1),
        .d        (d),
        .ym_bdir  (ym_bdir),
        .ym_bc1   (ym_bc1),
        .ym_sel   (ym_sel),
        .ym_dout  (ym_dout),
        .ym_doe   (ym_doe),
        .wait_n   (wait_n),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 cpu_clock = ~cpu_clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: each accepted entry has a push edge and the edge its bus cycle starts.
    int         e_push[$];
    int         e_pop[$];
    logic [1:0] e_kind[$];
    logic [7:0] e_data[$];
    int         bus_free = 0;
    int         ovf_edge = NEVER;
    bit         in_read = 1'b0;
    bit         prev_wr = 1'b0;

    function automatic int bus_entry(int k);
        for (int i = 0; i < e_pop.size(); i++)
            if (e_kind[i] != K_SEL && k >= e_pop[i] && k <= e_pop[i] + SETUP_CYC + PULSE_CYC)
                return i;
        return -1;
    endfunction

    function automatic bit queued(int k);
        for (int i = 0; i < e_pop.size(); i++)
            if (e_push[i] <= k && k < e_pop[i])
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] sel_at(int k);
        logic [1:0] s = 2'b10;
        for (int i = 0; i < e_pop.size(); i++)
            if (e_kind[i] == K_SEL && e_pop[i] <= k)
                s = e_data[i][0] ? 2'b01 : 2'b10;
        return s;
    endfunction

    function automatic void schedule(int p, logic [1:0] kind, logic [7:0] data);
        int held = 0;
        int pop_at;
        for (int i = 0; i < e_pop.size(); i++)
            if (e_push[i] < p && e_pop[i] > p)
                held++;
        if (held >= DEPTH) begin
            if (ovf_edge == NEVER)
                ovf_edge = p;
            return;
        end
        pop_at = (p + 1 > bus_free) ? p + 1 : bus_free;
        e_push.push_back(p);
        e_pop.push_back(pop_at);
        e_kind.push_back(kind);
        e_data.push_back(data);
        bus_free = (kind == K_SEL) ? pop_at + 1 : pop_at + SETUP_CYC + PULSE_CYC + 2;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        int   i;
        bit   rd_now, pend, bdir_e, bc1_e;
        i      = bus_entry(cyc);
        rd_now = !iorq && wr && m1 && a15 && a14 && !a1;
        pend   = queued(cyc);
        bdir_e = 1'b0;
        bc1_e  = in_read;
        if (i >= 0) begin
            bdir_e = (cyc >= e_pop[i] + SETUP_CYC) && (cyc < e_pop[i] + SETUP_CYC + PULSE_CYC);
            if (bdir_e && e_kind[i] == K_ADDR)
                bc1_e = 1'b1;
        end
        chk("bdir", ym_bdir, bdir_e);
        chk("bc1", ym_bc1, bc1_e);
        chk("doe", ym_doe, i >= 0);
        if (i >= 0)
            chk("dout", ym_dout, e_data[i]);
        chk("sel", ym_sel, sel_at(cyc));
        chk("busy", busy, in_read || i >= 0 || pend);
        chk("wait_n", wait_n, !(rd_now && (pend || i >= 0)));
        chk("ovf", ovf, cyc >= ovf_edge);
    endtask

    task automatic step();
        bit wr_now, rd_now;
        @(posedge cpu_clock);
        cyc++;
        wr_now = !iorq && !wr && m1 && a15 && !a1;
        rd_now = !iorq && wr && m1 && a15 && a14 && !a1;
        if (in_read) begin
            if (!rd_now)
                in_read = 1'b0;
        end else if (rd_now && bus_entry(cyc - 1) < 0 && !queued(cyc - 1)) begin
            in_read = 1'b1;
        end
        if (wr_now && !prev_wr)
            schedule(cyc + 1, a14 ? ((d[7:3] == 5'b11111) ? K_SEL : K_ADDR) : K_DATA, d);
        prev_wr = wr_now;
        @(negedge cpu_clock);
        check_cycle();
    endtask

    task automatic idle_inputs();
        iorq = 1'b1; wr = 1'b1; m1 = 1'b1; a15 = 1'b0; a14 = 1'b0; a1 = 1'b0; d = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_bdir", ym_bdir, 0);
        chk("rst_bc1", ym_bc1, 0);
        chk("rst_doe", ym_doe, 0);
        chk("rst_dout", ym_dout, 8'h00);
        chk("rst_sel", ym_sel, 2'b10);
        chk("rst_wait_n", wait_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        e_push.delete(); e_pop.delete(); e_kind.delete(); e_data.delete();
        bus_free = 0; ovf_edge = NEVER; in_read = 1'b0; prev_wr = 1'b0;
        idle_inputs();
        repeat (2) @(posedge cpu_clock);
        @(negedge cpu_clock);
        reset = 1'b1;
    endtask

    task automatic cpu_out(input bit port_a14, input logic [7:0] data, input int len);
        iorq = 1'b0; wr = 1'b0; m1 = 1'b1; a15 = 1'b1; a14 = port_a14; a1 = 1'b0; d = data;
        repeat (len) step();
        iorq = 1'b1; wr = 1'b1;
        step();
    endtask

    task automatic cpu_in(input int hold, input bit expect_wait);
        iorq = 1'b0; wr = 1'b1; m1 = 1'b1; a15 = 1'b1; a14 = 1'b1; a1 = 1'b0;
        step();
        if (expect_wait)
            chk("wait_on_busy_read", wait_n, 0);
        for (int n = 0; n < 60 && !(ym_bc1 && wait_n && !ym_doe); n++)
            step();
        chk("read_phase", {ym_bdir, ym_bc1, ym_doe, wait_n}, 4'b0101);
        repeat (hold) step();
        iorq = 1'b1;
        step();
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && busy; n++)
            step();
        chk("drain_idle", busy, 0);
    endtask

    task automatic wait_strobe(input bit want_bc1);
        for (int n = 0; n < 60 && !(ym_bdir && ym_bc1 == want_bc1); n++)
            step();
        chk("strobe_seen", {ym_bdir, ym_bc1}, {1'b1, want_bc1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] rv;
    int         rsel;

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // Address then data write, strict order.
        cpu_out(1'b1, 8'h07, 1);
        cpu_out(1'b0, 8'h3E, 1);
        drain();

        // Chip-select commands never touch the strobes.
        cpu_out(1'b1, 8'hFE, 2);
        drain();
        chk("sel_fe", ym_sel, 2'b10);
        cpu_out(1'b1, 8'hFF, 1);
        drain();
        chk("sel_ff", ym_sel, 2'b01);
        cpu_out(1'b1, 8'hFE, 3);
        drain();
        chk("sel_fe_again", ym_sel, 2'b10);

        // Back-to-back OUTs while a cycle is mid-strobe overflow the queue.
        cpu_out(1'b1, 8'h07, 1);
        wait_strobe(1'b1);
        for (int n = 0; n < 10; n++)
            cpu_out(n[0], 8'h40 + 8'(n), 1);
        drain();
        chk("ovf_sticky", ovf, 1);

        // Read arriving behind queued writes is held off until they drain.
        do_reset();
        cpu_out(1'b1, 8'h08, 1);
        cpu_out(1'b0, 8'h55, 1);
        cpu_in(3, 1'b1);
        drain();

        // Reset in the middle of a data strobe.
        cpu_out(1'b1, 8'hFF, 1);
        cpu_out(1'b1, 8'h0B, 1);
        cpu_out(1'b0, 8'hA5, 1);
        cpu_out(1'b0, 8'h5A, 1);
        wait_strobe(1'b0);
        #2;
        do_reset();
        repeat (12) step();

        // Interrupt acknowledge must be ignored.
        iorq = 1'b0; m1 = 1'b0; a15 = 1'b1; a14 = 1'b1; a1 = 1'b0; wr = 1'b0; d = 8'h07;
        repeat (3) step();
        wr = 1'b1;
        repeat (3) step();
        chk("intack_busy", busy, 0);
        chk("intack_wait_n", wait_n, 1);
        idle_inputs();
        step();

        // Randomized traffic mixing all entry types, gaps and reads.
        for (int n = 0; n < 80; n++) begin
            rsel = $urandom_range(0, 9);
            if (rsel == 0) begin
                cpu_in($urandom_range(0, 3), 1'b0);
            end else begin
                rv = 8'($urandom_range(0, 255));
                if (rsel == 1)
                    rv = {5'b11111, 3'($urandom_range(0, 7))};
                cpu_out(1'($urandom_range(0, 1)), rv, $urandom_range(1, 3));
                repeat ($urandom_range(0, 4)) step();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
